// File: rtl/ne_rx_ring_ctrl_pkg.sv
// Shared definitions for the NE2000 receive-ring sequencer: FSM states,
// page/header constants, ISR bit positions and the ring page-advance helper.
package ne_rx_ring_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_DATA  = 3'd2,
      ST_DROP  = 3'd3,
      ST_HDR   = 3'd4
   } rx_state_e;

   localparam int unsigned NE_PAGE_SIZE     = 256;
   localparam int unsigned NE_HDR_LEN       = 4;
   localparam logic [7:0]  NE_HDR_STATUS_OK = 8'h01;
   localparam int unsigned NE_ISR_PRX_BIT   = 0;
   localparam int unsigned NE_ISR_OVW_BIT   = 4;
   localparam int unsigned NE_MIN_LEN       = 60;
   localparam int unsigned NE_MAX_LEN       = 1514;

   // Page following 'page' inside the ring; the last page (pstop-1) wraps to pstart.
   function automatic logic [7:0] ring_next_page(input logic [7:0] page,
                                                 input logic [7:0] pstart,
                                                 input logic [7:0] pstop);
      logic [7:0] nxt;
      if (page == (pstop - 8'd1)) begin
         nxt = pstart;
      end else begin
         nxt = page + 8'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/ne_rx_ring_ctrl_if.sv
// Receive stream from the io controller plus the rx buffer RAM write port.
// master = io controller / RAM side, slave = ring sequencer.
interface ne_rx_ring_ctrl_if;
   logic        rx_start;
   logic [10:0] rx_len;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        rx_busy;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;

   modport master (
      output rx_start, rx_len, rx_valid, rx_data,
      input  rx_ready, rx_busy, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  rx_start, rx_len, rx_valid, rx_data,
      output rx_ready, rx_busy, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/ne_rx_ring_ctrl_ring_space.sv
// Combinational ring-space calculation: pages a frame needs (header included)
// and pages free between the write pointer and the CPU boundary.
module ne_ring_space
   import ne_rx_ring_ctrl_pkg::*;
(
   input  logic [7:0]  pstart_i,
   input  logic [7:0]  pstop_i,
   input  logic [7:0]  bnry_i,
   input  logic [7:0]  curr_i,
   input  logic [10:0] len_i,
   output logic [15:0] need_o,
   output logic [7:0]  free_o
);
   logic [7:0] ring_s;
   logic [8:0] raw_s;

   // One page is always kept empty so curr never catches up with bnry; a
   // degenerate ring (empty or inverted) reports no free space at all.
   always_comb begin
      ring_s = pstop_i - pstart_i;
      need_o = ({5'd0, len_i} + 16'(NE_HDR_LEN) + 16'(NE_PAGE_SIZE - 1)) >> 8;
      raw_s  = {1'b0, bnry_i} + {1'b0, ring_s} - {1'b0, curr_i} - 9'd1;
      if ((ring_s == 8'd0) || (pstop_i < pstart_i)) begin
         free_o = 8'd0;
      end else begin
         free_o = 8'(raw_s % {1'b0, ring_s});
      end
   end
endmodule

// File: rtl/ne_rx_ring_ctrl.sv
// NE2000 receive-ring sequencer: admits or drops each frame, streams the
// payload into ring pages behind a 4-byte header slot, then writes the header,
// advances curr and pulses PRX (or pulses OVW when there is no room).
module ne_rx_ring_ctrl
   import ne_rx_ring_ctrl_pkg::*;
#(
   parameter int unsigned MIN_LEN = NE_MIN_LEN,
   parameter int unsigned MAX_LEN = NE_MAX_LEN
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic [7:0]       pstart,
   input  logic [7:0]       pstop,
   input  logic [7:0]       bnry,
   input  logic             curr_we,
   input  logic [7:0]       curr_wdata,
   output logic [7:0]       curr,
   ne_rx_ring_ctrl_if.slave rx_if,
   output logic             prx_pulse,
   output logic             ovw_pulse
);
   localparam logic [10:0] MIN_LEN_C = 11'(MIN_LEN);
   localparam logic [10:0] MAX_LEN_C = 11'(MAX_LEN);

   rx_state_e   state_q, state_d;
   logic [10:0] len_q, cnt_q;
   logic [7:0]  start_page_q, wpage_q, woff_q, next_page_q, curr_q;
   logic [1:0]  hdr_idx_q;
   logic        prx_q;

   logic [15:0] need_s, len4_s;
   logic [7:0]  free_s;
   logic        runt_s, drop_ovw_s, rdy_s, hs_s, last_s, commit_s;

   ne_ring_space u_space (
      .pstart_i (pstart),
      .pstop_i  (pstop),
      .bnry_i   (bnry),
      .curr_i   (start_page_q),
      .len_i    (len_q),
      .need_o   (need_s),
      .free_o   (free_s)
   );

   // Frame classification and byte handshake; flush blocks any transfer this cycle.
   always_comb begin
      len4_s     = {5'd0, len_q} + 16'(NE_HDR_LEN);
      runt_s     = (len_q < MIN_LEN_C);
      drop_ovw_s = (len_q > MAX_LEN_C) || (need_s > {8'd0, free_s});
      rdy_s      = ((state_q == ST_DATA) || (state_q == ST_DROP)) && !flush;
      hs_s       = rdy_s && rx_if.rx_valid;
      last_s     = (cnt_q == (len_q - 11'd1));
      commit_s   = (state_q == ST_HDR) && (hdr_idx_q == 2'd3) && !flush;
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; flush overrides everything.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (rx_if.rx_start) state_d = ST_CHECK;
               else                state_d = ST_IDLE;
            end
            ST_CHECK: begin
               if (runt_s || drop_ovw_s) begin
                  if (len_q == 11'd0) state_d = ST_IDLE;
                  else                state_d = ST_DROP;
               end else begin
                  state_d = ST_DATA;
               end
            end
            ST_DATA: begin
               if (hs_s && last_s) state_d = ST_HDR;
               else                state_d = ST_DATA;
            end
            ST_DROP: begin
               if (hs_s && last_s) state_d = ST_IDLE;
               else                state_d = ST_DROP;
            end
            ST_HDR: begin
               if (hdr_idx_q == 2'd3) state_d = ST_IDLE;
               else                   state_d = ST_HDR;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Outputs: payload writes follow the handshake in the same cycle, header bytes come from a mux.
   always_comb begin
      rx_if.rx_ready  = rdy_s;
      rx_if.rx_busy   = (state_q != ST_IDLE);
      rx_if.mem_we    = 1'b0;
      rx_if.mem_addr  = 16'h0000;
      rx_if.mem_wdata = 8'h00;
      ovw_pulse       = 1'b0;
      curr            = curr_q;
      prx_pulse       = prx_q;
      case (state_q)
         ST_CHECK: begin
            ovw_pulse = !flush && !runt_s && drop_ovw_s;
         end
         ST_DATA: begin
            if (hs_s) begin
               rx_if.mem_we    = 1'b1;
               rx_if.mem_addr  = {wpage_q, woff_q};
               rx_if.mem_wdata = rx_if.rx_data;
            end else begin
               rx_if.mem_we    = 1'b0;
            end
         end
         ST_HDR: begin
            if (!flush) begin
               rx_if.mem_we   = 1'b1;
               rx_if.mem_addr = {start_page_q, 6'd0, hdr_idx_q};
               case (hdr_idx_q)
                  2'd0:    rx_if.mem_wdata = NE_HDR_STATUS_OK;
                  2'd1:    rx_if.mem_wdata = next_page_q;
                  2'd2:    rx_if.mem_wdata = len4_s[7:0];
                  default: rx_if.mem_wdata = len4_s[15:8];
               endcase
            end else begin
               rx_if.mem_we   = 1'b0;
            end
         end
         default: begin
            ovw_pulse = 1'b0;
         end
      endcase
   end

   // Datapath: curr (commit beats CPU write), frame latch, write pointer, counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         curr_q       <= 8'd0;
         prx_q        <= 1'b0;
         len_q        <= 11'd0;
         cnt_q        <= 11'd0;
         start_page_q <= 8'd0;
         wpage_q      <= 8'd0;
         woff_q       <= 8'd0;
         next_page_q  <= 8'd0;
         hdr_idx_q    <= 2'd0;
      end else begin
         prx_q <= commit_s;
         if (commit_s) begin
            curr_q <= next_page_q;
         end else if (curr_we) begin
            curr_q <= curr_wdata;
         end else begin
            curr_q <= curr_q;
         end
         if ((state_q == ST_IDLE) && rx_if.rx_start && !flush) begin
            len_q        <= rx_if.rx_len;
            start_page_q <= curr_q;
            wpage_q      <= curr_q;
            woff_q       <= 8'h04;
            cnt_q        <= 11'd0;
            hdr_idx_q    <= 2'd0;
         end else if ((state_q == ST_DATA) && hs_s) begin
            cnt_q  <= cnt_q + 11'd1;
            woff_q <= woff_q + 8'd1;
            if (woff_q == 8'hFF) begin
               wpage_q <= ring_next_page(wpage_q, pstart, pstop);
            end
            if (last_s) begin
               next_page_q <= ring_next_page(wpage_q, pstart, pstop);
            end
         end else if ((state_q == ST_DROP) && hs_s) begin
            cnt_q <= cnt_q + 11'd1;
         end else if ((state_q == ST_HDR) && !flush) begin
            hdr_idx_q <= hdr_idx_q + 2'd1;
         end
      end
   end
endmodule

// File: tb/tb_ne_rx_ring_ctrl.sv
// Bench for ne_rx_ring_ctrl: directed ring scenarios plus randomized frames,
// scored against a page-arithmetic model of the receive ring.
module tb_ne_rx_ring_ctrl;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       flush = 1'b0;
   logic [7:0] pstart, pstop, bnry, curr_wdata, curr;
   logic       curr_we, prx_pulse, ovw_pulse;

   ne_rx_ring_ctrl_if rif();

   ne_rx_ring_ctrl dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (flush),
      .pstart     (pstart),
      .pstop      (pstop),
      .bnry       (bnry),
      .curr_we    (curr_we),
      .curr_wdata (curr_wdata),
      .curr       (curr),
      .rx_if      (rif.slave),
      .prx_pulse  (prx_pulse),
      .ovw_pulse  (ovw_pulse)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [15:0] addr; logic [7:0] data; } wr_t;
   localparam int EV_PRX = 1;
   localparam int EV_OVW = 2;

   wr_t        exp_wr_q[$];
   wr_t        dut_wr_q[$];
   int         exp_ev_q[$];
   int         n_checks = 0, n_fail = 0, prx_cnt = 0, ovw_cnt = 0;
   int         m_curr = 0;
   logic [7:0] payload [0:2047];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic wr_t dwr(input int i);
      wr_t w;
      w = '1;
      if (i < dut_wr_q.size()) w = dut_wr_q[i];
      return w;
   endfunction

   // Free pages between write pointer and boundary, one page held in reserve.
   function automatic int m_free(input int ps, input int pe, input int bn, input int cu);
      int ring;
      ring = pe - ps;
      if (ring <= 0) return 0;
      return (((bn - cu - 1) % ring) + ring) % ring;
   endfunction

   // Page holding byte 'pos' of a frame that starts at page 'start' of the ring.
   function automatic int m_page(input int ps, input int pe, input int start, input int pos);
      return ps + ((start - ps) + pos / 256) % (pe - ps);
   endfunction

   // Predicts writes and pulses of one frame; fa >= 0 means aborted after fa bytes.
   task automatic model_frame(input int len, inout int fa, output int kind, output int new_curr);
      int  need, np, len4;
      wr_t w;
      need     = (len + 4 + 255) / 256;
      new_curr = m_curr;
      if (len < 60) kind = 0;
      else if (len > 1514 || need > m_free(pstart, pstop, bnry, m_curr)) kind = 1;
      else kind = 2;
      if (kind == 1) exp_ev_q.push_back(EV_OVW);
      if (kind != 2) fa = -1;
      if (kind == 2) begin
         for (int i = 0; i < ((fa >= 0) ? fa : len); i++) begin
            w.addr = 16'(m_page(pstart, pstop, m_curr, i + 4) * 256 + (i + 4) % 256);
            w.data = payload[i];
            exp_wr_q.push_back(w);
         end
         if (fa < 0) begin
            np   = m_page(pstart, pstop, m_curr, need * 256);
            len4 = len + 4;
            w.addr = 16'(m_curr * 256 + 0); w.data = 8'h01;             exp_wr_q.push_back(w);
            w.addr = 16'(m_curr * 256 + 1); w.data = 8'(np);            exp_wr_q.push_back(w);
            w.addr = 16'(m_curr * 256 + 2); w.data = 8'(len4 % 256);    exp_wr_q.push_back(w);
            w.addr = 16'(m_curr * 256 + 3); w.data = 8'(len4 / 256);    exp_wr_q.push_back(w);
            exp_ev_q.push_back(EV_PRX);
            new_curr = np;
         end
      end
   endtask

   // Per-cycle scoreboard: every write and pulse must match the model's next expectation.
   always @(negedge clk) begin
      if (reset_n) begin
         if (rif.mem_we) begin
            dut_wr_q.push_back({rif.mem_addr, rif.mem_wdata});
            chk("write_expected", exp_wr_q.size() > 0, 1);
            if (exp_wr_q.size() > 0) chk("write", {rif.mem_addr, rif.mem_wdata}, exp_wr_q.pop_front());
            if (rif.rx_ready) chk("write_on_handshake", rif.rx_valid, 1);
         end
         if (prx_pulse) begin
            prx_cnt++;
            chk("prx_expected", exp_ev_q.size() > 0, 1);
            if (exp_ev_q.size() > 0) chk("prx_event", exp_ev_q.pop_front(), EV_PRX);
         end
         if (ovw_pulse) begin
            ovw_cnt++;
            chk("ovw_expected", exp_ev_q.size() > 0, 1);
            if (exp_ev_q.size() > 0) chk("ovw_event", exp_ev_q.pop_front(), EV_OVW);
         end
      end
   end

   task automatic set_curr(input int v);
      curr_we = 1'b1; curr_wdata = 8'(v);
      @(posedge clk); #1;
      curr_we = 1'b0;
      m_curr = v;
   endtask

   // Streams one frame; fa aborts after fa bytes by flush (or by reset when rst_mode).
   task automatic run_frame(input int len, input int fa_in, input bit rst_mode, input bit cw_commit);
      int fa, kind, new_curr, sent, budget, start_pg;
      bit aborted;
      fa = fa_in; aborted = 1'b0;
      for (int i = 0; i < len; i++) payload[i] = 8'($urandom_range(0, 255));
      start_pg = m_curr;
      model_frame(len, fa, kind, new_curr);
      rif.rx_start = 1'b1; rif.rx_len = 11'(len);
      @(posedge clk); #1;
      rif.rx_start = 1'b0;
      sent = 0; budget = 8 * len + 64;
      while (sent < len && budget > 0) begin
         if (sent == fa) begin
            aborted = 1'b1;
            rif.rx_valid = 1'b0;
            if (rst_mode) begin
               #2 reset_n = 1'b0;
               #1;
               chk("rst_outputs_zero", {curr, rif.rx_ready, rif.rx_busy, rif.mem_we, rif.mem_addr,
                                        rif.mem_wdata, prx_pulse, ovw_pulse}, 0);
               exp_wr_q.delete(); exp_ev_q.delete(); new_curr = 0;
               @(posedge clk); @(posedge clk); #1;
               reset_n = 1'b1;
               chk("rst_release_idle", rif.rx_busy, 0);
            end else begin
               flush = 1'b1;
               @(posedge clk); #1;
               flush = 1'b0;
               @(negedge clk);
               chk("flush_idle", rif.rx_busy, 0);
               @(posedge clk); #1;
            end
            break;
         end
         rif.rx_valid = ($urandom_range(0, 3) != 0);
         rif.rx_data  = payload[sent];
         @(negedge clk);
         if (rif.rx_valid && rif.rx_ready) sent++;
         @(posedge clk); #1;
         budget--;
      end
      rif.rx_valid = 1'b0;
      if (!aborted) chk("bytes_consumed", sent, len);
      budget = 40;
      while (rif.rx_busy && budget > 0) begin
         curr_we = 1'b0;
         if (cw_commit && rif.mem_we && rif.mem_addr == 16'(start_pg * 256 + 3)) begin
            curr_we = 1'b1; curr_wdata = 8'h50;
         end
         @(posedge clk); #1;
         budget--;
      end
      curr_we = 1'b0;
      chk("busy_drop", budget > 0, 1);
      @(negedge clk); #1;
      m_curr = new_curr;
      chk("curr", curr, m_curr);
      chk("wr_drain", exp_wr_q.size(), 0);
      chk("ev_drain", exp_ev_q.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1);
   end

   initial begin
      int p_ovw, p_prx, len, fa;
      pstart = 8'h46; pstop = 8'h60; bnry = 8'h46;
      curr_we = 1'b0; curr_wdata = 8'h00;
      rif.rx_start = 1'b0; rif.rx_len = 11'd0; rif.rx_valid = 1'b0; rif.rx_data = 8'h00;
      #12;
      chk("reset_outputs_zero", {curr, rif.rx_ready, rif.rx_busy, rif.mem_we, rif.mem_addr,
                                 rif.mem_wdata, prx_pulse, ovw_pulse}, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      chk("reset_curr", curr, 8'h00);
      chk("model_free_pin_a", m_free(8'h46, 8'h60, 8'h46, 8'h47), 24);
      chk("model_free_pin_b", m_free(8'h46, 8'h60, 8'h48, 8'h47), 0);

      // Case 1: simple frame
      set_curr(8'h47); dut_wr_q.delete();
      run_frame(60, -1, 1'b0, 1'b0);
      chk("t1_nwrites", dut_wr_q.size(), 64);
      chk("t1_first", dwr(0).addr, 16'h4704);
      chk("t1_last", dwr(59).addr, 16'h473F);
      chk("t1_hdr0", dwr(60), {16'h4700, 8'h01});
      chk("t1_hdr1", dwr(61), {16'h4701, 8'h48});
      chk("t1_hdr2", dwr(62), {16'h4702, 8'h40});
      chk("t1_hdr3", dwr(63), {16'h4703, 8'h00});
      chk("t1_curr", curr, 8'h48);

      // Case 2: wrap at pstop
      bnry = 8'h50; set_curr(8'h5F); dut_wr_q.delete();
      run_frame(300, -1, 1'b0, 1'b0);
      chk("t2_b251", dwr(251).addr, 16'h5FFF);
      chk("t2_b252", dwr(252).addr, 16'h4600);
      chk("t2_hdr1", dwr(301), {16'h5F01, 8'h47});
      chk("t2_hdr2", dwr(302), {16'h5F02, 8'h30});
      chk("t2_hdr3", dwr(303), {16'h5F03, 8'h01});

      // Case 3: ring full
      bnry = 8'h48; set_curr(8'h47); dut_wr_q.delete(); p_ovw = ovw_cnt;
      run_frame(300, -1, 1'b0, 1'b0);
      chk("t3_ovw", ovw_cnt - p_ovw, 1);
      chk("t3_nwrites", dut_wr_q.size(), 0);
      chk("t3_curr", curr, 8'h47);

      // Case 4: runt and oversize
      bnry = 8'h46; p_ovw = ovw_cnt; p_prx = prx_cnt;
      run_frame(40, -1, 1'b0, 1'b0);
      chk("t4_runt_silent", {ovw_cnt - p_ovw, prx_cnt - p_prx, dut_wr_q.size()}, 0);
      run_frame(1515, -1, 1'b0, 1'b0);
      chk("t4_oversize_ovw", ovw_cnt - p_ovw, 1);
      chk("t4_nwrites", dut_wr_q.size(), 0);

      // Case 5: flush mid-frame then a good frame
      p_prx = prx_cnt;
      run_frame(100, 10, 1'b0, 1'b0);
      chk("t5_nwrites", dut_wr_q.size(), 10);
      chk("t5_no_prx", prx_cnt - p_prx, 0);
      chk("t5_curr", curr, 8'h47);
      run_frame(60, -1, 1'b0, 1'b0);
      chk("t5_next_curr", curr, 8'h48);

      // Case 6: CPU write of curr in commit cycle loses; elsewhere it wins
      set_curr(8'h47);
      run_frame(60, -1, 1'b0, 1'b1);
      chk("t6_commit_wins", curr, 8'h48);
      set_curr(8'h50);
      chk("t6_cpu_write", curr, 8'h50);

      // Case 7: reset mid-DATA
      set_curr(8'h47);
      run_frame(200, 20, 1'b1, 1'b0);
      chk("t7_curr_zero", curr, 8'h00);

      // Randomized frames over random rings
      for (int i = 0; i < 30; i++) begin
         if (i % 6 == 0) begin
            pstart = 8'($urandom_range(8'h10, 8'h80));
            pstop  = pstart + 8'($urandom_range(2, 40));
            set_curr(pstart + $urandom_range(0, pstop - pstart - 1));
         end else if (i % 7 == 3) begin
            set_curr(pstart + $urandom_range(0, pstop - pstart - 1));
         end
         bnry = pstart + 8'($urandom_range(0, pstop - pstart - 1));
         case ($urandom_range(0, 9))
            0:       len = $urandom_range(0, 59);
            1:       len = $urandom_range(1515, 1700);
            default: len = $urandom_range(60, 700);
         endcase
         fa = ($urandom_range(0, 7) == 0) ? $urandom_range(1, len - 1) : -1;
         if (len < 2) fa = -1;
         run_frame(len, fa, 1'b0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
